// File: rtl/measurement_sequencer.sv
// Measurement sequencer: clears the lock-in datapath, accumulates N_REP results, then runs the amplitude step.
// Optional feature: define MEAS_SEQ_CONTINUOUS_EN for back-to-back free-running measurements.
module measurement_sequencer #(
   parameter int Q_RES       = 50,
   parameter int N_REP       = 4,
   parameter int CLR_CYC     = 4,
   parameter int TIMEOUT_CYC = 1048576,
   localparam int RW         = $clog2(N_REP + 1)
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        start,
   input  logic                        abort,
   output logic                        dp_reset_n,
   output logic                        dp_enable,
   input  logic                        res_valid,
   input  logic signed [Q_RES-1:0]     res_fase,
   input  logic signed [Q_RES-1:0]     res_cuad,
   output logic                        amp_start,
   input  logic                        amp_done,
   output logic signed [Q_RES+RW-1:0]  acc_fase,
   output logic signed [Q_RES+RW-1:0]  acc_cuad,
   output logic [7:0]                  rep_count,
   output logic                        busy,
   output logic                        done,
   output logic                        timeout
);

   localparam int AW = Q_RES + RW;
   localparam int CW = $clog2(CLR_CYC + 1);
   localparam int WW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CW-1:0] CLR_LAST  = CW'(CLR_CYC - 1);
   localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT_CYC - 1);
   localparam logic [7:0]    REP_LAST  = 8'(N_REP - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_CLEAR, S_ARM, S_AMP, S_DONE, S_ERROR
   } state_t;

   state_t         state;
   logic [CW-1:0]  clr_cnt;
   logic [WW-1:0]  wait_cnt;

   // RW guard bits make N_REP full-scale results impossible to overflow.
   logic signed [AW-1:0] fase_ext;
   logic signed [AW-1:0] cuad_ext;
   assign fase_ext = {{RW{res_fase[Q_RES-1]}}, res_fase};
   assign cuad_ext = {{RW{res_cuad[Q_RES-1]}}, res_cuad};

   // NOTE: every register, accumulators included, is reset; they are plain flops, not a memory.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= S_IDLE;
         clr_cnt    <= '0;
         wait_cnt   <= '0;
         dp_reset_n <= 1'b0;
         dp_enable  <= 1'b0;
         amp_start  <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         timeout    <= 1'b0;
         rep_count  <= '0;
         acc_fase   <= '0;
         acc_cuad   <= '0;
      end else begin
         // NOTE: non-blocking throughout, so later assignments in this block override these pulse defaults.
         amp_start <= 1'b0;
         done      <= 1'b0;
         if (abort) begin
            state      <= S_IDLE;
            dp_enable  <= 1'b0;
            dp_reset_n <= 1'b1;
            busy       <= 1'b0;
         end else begin
            case (state)
               S_IDLE: begin
                  dp_reset_n <= 1'b1;
                  if (start) begin
                     state      <= S_CLEAR;
                     busy       <= 1'b1;
                     timeout    <= 1'b0;
                     rep_count  <= '0;
                     acc_fase   <= '0;
                     acc_cuad   <= '0;
                     clr_cnt    <= '0;
                     dp_reset_n <= 1'b0;
                     dp_enable  <= 1'b0;
                  end
               end
               S_CLEAR: begin
                  if (clr_cnt == CLR_LAST) begin
                     state      <= S_ARM;
                     dp_reset_n <= 1'b1;
                     dp_enable  <= 1'b1;
                     wait_cnt   <= '0;
                  end else begin
                     clr_cnt <= clr_cnt + 1'b1;
                  end
               end
               S_ARM: begin
                  if (res_valid) begin
                     acc_fase  <= acc_fase + fase_ext;
                     acc_cuad  <= acc_cuad + cuad_ext;
                     rep_count <= rep_count + 1'b1;
                     dp_enable <= 1'b0;
                     if (rep_count == REP_LAST) begin
                        state     <= S_AMP;
                        amp_start <= 1'b1;
                        wait_cnt  <= '0;
                     end else begin
                        state      <= S_CLEAR;
                        dp_reset_n <= 1'b0;
                        clr_cnt    <= '0;
                     end
                  end else if (wait_cnt == WAIT_LAST) begin
                     state     <= S_ERROR;
                     timeout   <= 1'b1;
                     busy      <= 1'b0;
                     dp_enable <= 1'b0;
                  end else begin
                     wait_cnt <= wait_cnt + 1'b1;
                  end
               end
               S_AMP: begin
                  if (amp_done) begin
                     state <= S_DONE;
                     done  <= 1'b1;
                  end else if (wait_cnt == WAIT_LAST) begin
                     state   <= S_ERROR;
                     timeout <= 1'b1;
                     busy    <= 1'b0;
                  end else begin
                     wait_cnt <= wait_cnt + 1'b1;
                  end
               end
               S_DONE: begin
`ifdef MEAS_SEQ_CONTINUOUS_EN
                  state      <= S_CLEAR;
                  rep_count  <= '0;
                  acc_fase   <= '0;
                  acc_cuad   <= '0;
                  clr_cnt    <= '0;
                  dp_reset_n <= 1'b0;
`else
                  state <= S_IDLE;
                  busy  <= 1'b0;
`endif
               end
               S_ERROR: state <= S_IDLE;
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: doc/measurement_sequencer.md
MEASUREMENT_SEQUENCER -- requirements
Module: measurement_sequencer

Interface
REQ-001 SHALL have parameter Q_RES, default 50: width of the lock-in phase and quadrature result words.
REQ-002 SHALL have parameter N_REP, default 4, range 1..255: number of lock-in results accumulated per measurement.
REQ-003 SHALL have parameter CLR_CYC, default 4: number of cycles that datapath clear is held asserted.
REQ-004 SHALL have parameter TIMEOUT_CYC, default 1048576: cycle limit while waiting in ARM or AMP.
REQ-005 SHALL have port clk, input, 1 bit: the single clock for the block.
REQ-006 SHALL have port reset, input, 1 bit: one clock; reset is asynchronous and active-high.
REQ-007 SHALL have port start, input, 1 bit: single-cycle request to begin a measurement.
REQ-008 SHALL have port abort, input, 1 bit: cancels any measurement in progress.
REQ-009 SHALL have port dp_reset_n, output, 1 bit: active-low clear driven to the averager and lock-in datapath.
REQ-010 SHALL have port dp_enable, output, 1 bit: datapath and data-source enable.
REQ-011 SHALL have port res_valid, input, 1 bit: lock-in data_out_valid.
REQ-012 SHALL have ports res_fase and res_cuad, input, Q_RES bits each, two's complement: lock-in results.
REQ-013 SHALL have port amp_start, output, 1 bit: start pulse to the amplitude calculator.
REQ-014 SHALL have port amp_done, input, 1 bit: amplitude calculator completion.
REQ-015 SHALL have ports acc_fase and acc_cuad, output, Q_RES+RW bits each, signed, where RW = clog2(N_REP+1): accumulated sums.
REQ-016 SHALL have port rep_count, output, 8 bits: number of results captured in the current measurement.
REQ-017 SHALL have ports busy (level), done (1-cycle pulse) and timeout (sticky), output, 1 bit each.

Function
REQ-018 SHALL implement the states IDLE, CLEAR, ARM, AMP, DONE and ERROR.
REQ-019 IDLE: start=1 SHALL move to CLEAR, clear acc_fase, acc_cuad, rep_count and timeout, and assert busy on the next cycle.
REQ-020 CLEAR SHALL hold dp_reset_n=0 and dp_enable=0 for exactly CLR_CYC cycles, then move to ARM.
REQ-021 ARM SHALL drive dp_enable=1 and dp_reset_n=1 and wait for res_valid.
REQ-022 res_valid in ARM SHALL add sign-extended res_fase and res_cuad into the accumulators and increment rep_count; the updated values SHALL be visible on the next cycle.
REQ-023 After that capture, the block SHALL go to AMP if rep_count reaches N_REP, otherwise to CLEAR for an independent run.
REQ-024 res_valid SHALL be ignored in every state except ARM.
REQ-025 On AMP entry, amp_start SHALL pulse for exactly 1 cycle and dp_enable SHALL be 0.
REQ-026 AMP SHALL wait for amp_done, then move to DONE.
REQ-027 DONE SHALL pulse done for 1 cycle, then return to IDLE with busy=0.
REQ-028 Accumulators SHALL remain stable from DONE until the next accepted start.
REQ-029 A wait-cycle counter SHALL reset on every entry to ARM or AMP.
REQ-030 If the wait-cycle counter reaches TIMEOUT_CYC before the awaited event, the block SHALL go to ERROR and set timeout=1 (busy=0, dp_enable=0).
REQ-031 ERROR SHALL return to IDLE on the next cycle; timeout SHALL stay at 1 until the next start.
REQ-032 abort=1 in any state SHALL force IDLE on the next cycle with dp_enable=0, dp_reset_n=1 and no done pulse; accumulators SHALL keep their partial values.
REQ-033 abort has priority over start, res_valid, amp_done and timeout in the same cycle.
REQ-034 start while busy=1 SHALL be ignored.
REQ-035 Accumulation SHALL not overflow: each result is sign-extended by RW bits.

Reset
REQ-036 reset=1 SHALL asynchronously force IDLE and set: dp_reset_n=0, dp_enable=0, amp_start=0, busy=0, done=0, timeout=0, rep_count=0, accumulators=0.
REQ-037 After reset deasserts, dp_reset_n SHALL read 1 from the first clock edge in IDLE.
REQ-038 reset asserted mid-measurement SHALL behave identically to REQ-036, including discarding any pending amp_done.

Configuration
REQ-039 When macro MEAS_SEQ_CONTINUOUS_EN is defined, DONE SHALL re-clear the accumulators and go to CLEAR, free-running until abort or reset; busy SHALL stay at 1.
REQ-040 When MEAS_SEQ_CONTINUOUS_EN is undefined, DONE SHALL go to IDLE as stated in REQ-027.

Verification
REQ-041 N_REP=4, res_fase=100 and res_cuad=-3 on each res_valid -> acc_fase=400, acc_cuad=-12, rep_count=4, one amp_start pulse, done 1 cycle after amp_done.
REQ-042 CLR_CYC=4, start -> dp_reset_n low for exactly 4 cycles before each ARM, and N_REP clears per measurement.
REQ-043 TIMEOUT_CYC=16 with no res_valid -> timeout=1 after 16 ARM cycles, busy=0, no done pulse; the next start clears timeout.
REQ-044 abort on the same cycle as res_valid with rep_count=2 -> IDLE, rep_count stays 2, dp_enable=0, no amp_start.
REQ-045 reset pulse during AMP followed by amp_done -> all outputs at reset values and no done pulse; a start during busy is also ignored.
REQ-046 MEAS_SEQ_CONTINUOUS_EN defined with N_REP=1 -> periodic done pulses, acc_fase equal to the single result each period.
